phase_timer: RTL and testbench
==============================

# phase_timer

Parametrised dwell timer for the traffic light controller. It generalises the fixed two-duration timer to `NUM_PHASES` phases. Each phase has its own run-time-programmable duration, and the timer adds hold (freeze) and optional per-phase extension (e.g. a pedestrian or sensor request). The controller FSM drives its current state into `phase` and advances on `time_out`.

## Interface
- `NUM_PHASES`, 4: number of controller phases (2..16).
- `PH_W`, 2: width of phase index, ≥ clog2(`NUM_PHASES`).
- `CNT_W`, 8: width of duration/count.
- `LONG_TICKS`, 10: reset duration of even phases (green).
- `SHORT_TICKS`, 3: reset duration of odd phases (yellow); both must be 1..2^`CNT_W`-1.
- `EXT_TICKS`, 5: ticks added per accepted extension.
- `MAX_EXT`, 2: extensions accepted per phase occurrence.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `phase`  in  `PH_W`  current controller phase.
- `hold`  in  1  freeze countdown while high.
- `ext_req`  in  1  extension request, sampled each cycle.
- `cfg_we`  in  1  duration table write strobe.
- `cfg_addr`  in  `PH_W`  phase index to write.
- `cfg_data`  in  `CNT_W`  new duration in ticks.
- `time_out`  out  1  level: current phase has expired.
- `remaining`  out  `CNT_W`  current count.
- `cfg_err`  out  1  one-cycle pulse: rejected cfg write.

## Operation
- State: `dur[NUM_PHASES]` table, `phase_q` (registered phase), `count`, `ext_cnt` (0..`MAX_EXT`), `cfg_err` register.
- Reset (`rst`=0 at edge):
  - `dur[i]` = `LONG_TICKS` for even i, `SHORT_TICKS` for odd i.
  - `phase_q`=0, `count`=`LONG_TICKS`, `ext_cnt`=0, `cfg_err`=0.
  - Outputs after reset: `time_out`=0, `remaining`=`LONG_TICKS`, `cfg_err`=0.
- Load: at any edge where `phase` != `phase_q`:
  - `count` <= `dur[phase]`, `ext_cnt` <= 0, `phase_q` <= `phase`.
  - Load has priority over hold, extension and decrement.
- Countdown: no load, `hold`=0, `count`>0 → `count` decrements by 1.
  - `count` never goes below 0.
  - At 0 it stays 0 until the next load; there is no auto-reload.
- `time_out` = (`count`==0), combinational from the register.
  - Stays high until the controller changes `phase`.
- `hold`=1 freezes `count`, including at 0.
- Config write accepted when `cfg_addr` < `NUM_PHASES` and `cfg_data` != 0.
  - `dur[cfg_addr]` updates at the edge.
  - Otherwise the table is unchanged and `cfg_err` pulses high for the next cycle.
  - A write never alters a running `count`; it takes effect at that phase's next load.
  - Write and load of the same phase at the same edge: load uses the old value.
- Extension: see Configuration.

## Timing
- Phase change visible on `phase` before edge t → `remaining`=`dur[phase]` after t.
  - With `hold`=0, `time_out` rises after edge t+`dur`; phase dwell is `dur`+1 cycles including the load cycle.
- Controller sees `time_out` combinationally and changes `phase` at the next edge; one cycle of `time_out`=1 per phase in normal flow.
- Phase `phase` != 0 held during reset → load occurs on the first edge after `rst` goes high.
- Reset mid-count: count aborts at that edge; no `time_out` generated by reset.
- `cfg_err` latency: one cycle after the offending strobe edge; width exactly one cycle per rejected write.

## Configuration
- Macro: `PHASE_TIMER_EXT_EN`.
- Defined — extension accepted when all of these hold at an edge:
  - `ext_req`=1, no load, `count`>0, `ext_cnt`<`MAX_EXT`.
  - Result: `count` <= min(`count`+`EXT_TICKS`, 2^`CNT_W`-1), `ext_cnt`+1, no decrement that cycle.
  - Also accepted while `hold`=1.
  - Requests at `count`==0 or beyond `MAX_EXT` are ignored.
- Undefined: `ext_req` is ignored, the `ext_cnt` logic is absent, and `count` follows countdown rules only.

## Test plan
- Reset with `phase`=0, run: `remaining` 10,9,…,0; `time_out` rises 10 cycles after reset release; switch to `phase`=1 → `remaining`=3 next cycle, `time_out` low.
- Write `cfg_addr`=2, `cfg_data`=7 during phase 1, then go to phase 2 → count starts at 7; write `cfg_data`=0 or `cfg_addr`=5 (`NUM_PHASES`=4) → table unchanged, `cfg_err` one-cycle pulse.
- `hold`=1 for 4 cycles at `remaining`=6 → stays 6, then resumes; hold at 0 → `time_out` stays high; phase change during hold → loads `dur`.
- With `PHASE_TIMER_EXT_EN`: `ext_req` at `remaining`=4 → 9; third request ignored; request at 0 ignored; `CNT_W`=4, `count`=14 + 5 → saturates at 15.
- `rst`=0 asserted at `remaining`=2 in phase 3 → `remaining`=10, `time_out`=0, table restored to 10/3/10/3.

Source files
------------

// File: rtl/phase_timer_if.sv
// Controller-side bundle for phase_timer: phase/hold/extension inputs,
// duration-table write port and the countdown status outputs.
interface phase_timer_if #(
    parameter int PH_W  = 2,
    parameter int CNT_W = 8
);
    logic [PH_W-1:0]  phase;
    logic             hold;
    logic             ext_req;
    logic             cfg_we;
    logic [PH_W-1:0]  cfg_addr;
    logic [CNT_W-1:0] cfg_data;
    logic             time_out;
    logic [CNT_W-1:0] remaining;
    logic             cfg_err;

    modport master (
        output phase, hold, ext_req, cfg_we, cfg_addr, cfg_data,
        input  time_out, remaining, cfg_err
    );

    modport slave (
        input  phase, hold, ext_req, cfg_we, cfg_addr, cfg_data,
        output time_out, remaining, cfg_err
    );
endinterface

// File: rtl/phase_timer.sv
// Per-phase dwell timer with programmable durations, hold and (when
// PHASE_TIMER_EXT_EN is defined) bounded, saturating per-phase extensions.
module phase_timer #(
    parameter int NUM_PHASES  = 4,
    parameter int PH_W        = 2,
    parameter int CNT_W       = 8,
    parameter int LONG_TICKS  = 10,
    parameter int SHORT_TICKS = 3,
    parameter int EXT_TICKS   = 5,
    parameter int MAX_EXT     = 2
) (
    input  logic          clk,
    input  logic          rst,
    phase_timer_if.slave  tmr
);
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_TICKS);

    logic [CNT_W-1:0] dur_q [NUM_PHASES];
    logic [CNT_W-1:0] count_q, count_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] load_val;
    logic             load;
    logic             cfg_ok;
    logic [NUM_PHASES-1:0] wr_hit;
    logic [NUM_PHASES-1:0] ld_hit;

    // Per-entry address decode for the table write and the load mux.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_decode
            assign wr_hit[gi] = cfg_ok && (tmr.cfg_addr == PH_W'(gi));
            assign ld_hit[gi] = (tmr.phase == PH_W'(gi));
        end
    endgenerate

    assign cfg_ok = tmr.cfg_we && (32'(tmr.cfg_addr) < 32'(NUM_PHASES))
                    && (tmr.cfg_data != '0);
    assign cfg_err_d = tmr.cfg_we && !cfg_ok;
    assign load = (tmr.phase != phase_q);

    // An out-of-range phase loads zero so the controller sees an immediate expiry.
    always_comb begin
        load_val = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (ld_hit[i]) begin
                load_val = dur_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                dur_q[i] <= (i % 2 == 0) ? LONG_C : SHORT_C;
            end
        end else begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (wr_hit[i]) begin
                    dur_q[i] <= tmr.cfg_data;
                end
            end
        end
    end

`ifdef PHASE_TIMER_EXT_EN
    localparam int EXT_W = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

    logic [EXT_W-1:0] ext_q, ext_d;
    logic [CNT_W:0]   ext_sum;
    logic             ext_ok;

    assign ext_ok  = tmr.ext_req && (count_q != '0) && (32'(ext_q) < 32'(MAX_EXT));
    assign ext_sum = {1'b0, count_q} + (CNT_W + 1)'(EXT_TICKS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_q <= '0;
        end else begin
            ext_q <= ext_d;
        end
    end
`else
    logic unused_ext_req;
    assign unused_ext_req = tmr.ext_req;
`endif

    // Load beats extension, extension beats hold/decrement.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
`ifdef PHASE_TIMER_EXT_EN
        ext_d   = ext_q;
`endif
        if (load) begin
            count_d = load_val;
            phase_d = tmr.phase;
`ifdef PHASE_TIMER_EXT_EN
            ext_d   = '0;
`endif
        end
`ifdef PHASE_TIMER_EXT_EN
        else if (ext_ok) begin
            count_d = ext_sum[CNT_W] ? '1 : ext_sum[CNT_W-1:0];
            ext_d   = ext_q + EXT_W'(1);
        end
`endif
        else if (!tmr.hold && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= LONG_C;
            phase_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            phase_q   <= phase_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign tmr.time_out  = (count_q == '0);
    assign tmr.remaining = count_q;
    assign tmr.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with a cycle-level reference model;
// extension checks follow PHASE_TIMER_EXT_EN.
module tb_phase_timer;
    localparam int NP    = 4;
    localparam int PHW   = 3;
    localparam int CW    = 8;
    localparam int LONG  = 10;
    localparam int SHORT = 3;
    localparam int EXTT  = 5;
    localparam int MAXE  = 2;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef PHASE_TIMER_EXT_EN
    localparam bit EXT_ON = 1'b1;
`else
    localparam bit EXT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phase_timer_if #(.PH_W(PHW), .CNT_W(CW)) bus ();

    phase_timer #(
        .NUM_PHASES(NP), .PH_W(PHW), .CNT_W(CW), .LONG_TICKS(LONG),
        .SHORT_TICKS(SHORT), .EXT_TICKS(EXTT), .MAX_EXT(MAXE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tmr(bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail_lines = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            if (n_fail_lines < 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
            n_fail_lines++;
        end
    endtask

    // Reference model: durations as ints, dwell as a plain integer count.
    int m_dur [NP];
    int m_count, m_ext, m_phase;
    bit m_err;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int a, d;
        bit ok;
        if (!rst) begin
            for (int i = 0; i < NP; i++) m_dur[i] = (i % 2 == 0) ? LONG : SHORT;
            m_phase = 0;
            m_count = LONG;
            m_ext   = 0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            a  = int'(bus.cfg_addr);
            d  = int'(bus.cfg_data);
            ok = bus.cfg_we && (a < NP) && (d != 0);
            if (int'(bus.phase) != m_phase) begin
                m_phase = int'(bus.phase);
                m_count = (m_phase < NP) ? m_dur[m_phase] : 0;
                m_ext   = 0;
            end else if (EXT_ON && bus.ext_req && m_count > 0 && m_ext < MAXE) begin
                m_count = (m_count + EXTT > CMAX) ? CMAX : m_count + EXTT;
                m_ext++;
            end else if (!bus.hold && m_count > 0) begin
                m_count--;
            end
            if (ok) m_dur[a] = d;
            m_err = bus.cfg_we && !ok;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("remaining", int'(bus.remaining), m_count);
            check("time_out", int'(bus.time_out), int'(m_count == 0));
            check("cfg_err", int'(bus.cfg_err), int'(m_err));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        bus.phase = '0; bus.hold = 1'b0; bus.ext_req = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        tick(2);
        check("rst_remaining", int'(bus.remaining), 10);
        check("rst_time_out", int'(bus.time_out), 0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);

        rst = 1'b1;
        tick(9);
        check("cnt_at_1", int'(bus.remaining), 1);
        check("to_before_expiry", int'(bus.time_out), 0);
        tick(1);
        check("cnt_at_0", int'(bus.remaining), 0);
        check("to_at_expiry", int'(bus.time_out), 1);
        tick(2);
        check("no_auto_reload", int'(bus.remaining), 0);

        bus.phase = 3'd1;
        tick(1);
        check("phase1_load", int'(bus.remaining), 3);
        check("phase1_to_low", int'(bus.time_out), 0);

        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_data = 8'd7;
        tick(1);
        check("good_write_no_err", int'(bus.cfg_err), 0);
        check("write_keeps_count", int'(bus.remaining), 2);
        bus.cfg_data = 8'd0;
        tick(1);
        check("zero_data_err", int'(bus.cfg_err), 1);
        bus.cfg_we = 1'b0;
        tick(1);
        check("err_one_cycle_a", int'(bus.cfg_err), 0);
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd5; bus.cfg_data = 8'd9;
        tick(1);
        check("bad_addr_err", int'(bus.cfg_err), 1);
        bus.cfg_we = 1'b0;
        tick(1);
        check("err_one_cycle_b", int'(bus.cfg_err), 0);

        bus.phase = 3'd2;
        tick(1);
        check("phase2_new_dur", int'(bus.remaining), 7);
        tick(1);
        bus.hold = 1'b1;
        tick(4);
        check("hold_freezes", int'(bus.remaining), 6);
        bus.hold = 1'b0;
        tick(1);
        check("hold_resume", int'(bus.remaining), 5);
        tick(5);
        check("phase2_expire", int'(bus.time_out), 1);
        bus.hold = 1'b1;
        tick(3);
        check("hold_at_zero_to", int'(bus.time_out), 1);
        bus.phase = 3'd3;
        tick(1);
        check("load_during_hold", int'(bus.remaining), 3);
        bus.hold = 1'b0;

        if (EXT_ON) begin
            bus.phase = 3'd0;
            tick(1);
            check("ext_phase0_load", int'(bus.remaining), 10);
            tick(6);
            check("ext_pre", int'(bus.remaining), 4);
            bus.ext_req = 1'b1;
            tick(1);
            check("ext_first", int'(bus.remaining), 9);
            tick(1);
            check("ext_second", int'(bus.remaining), 14);
            tick(1);
            check("ext_third_ignored", int'(bus.remaining), 13);
            bus.ext_req = 1'b0;
            tick(13);
            check("ext_run_out", int'(bus.time_out), 1);
            bus.ext_req = 1'b1;
            tick(1);
            check("ext_at_zero_ignored", int'(bus.remaining), 0);
            bus.ext_req = 1'b0;

            bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_data = 8'd252;
            tick(1);
            bus.cfg_we = 1'b0;
            bus.phase = 3'd1;
            tick(1);
            check("sat_load", int'(bus.remaining), 252);
            bus.ext_req = 1'b1;
            tick(1);
            check("ext_saturates", int'(bus.remaining), 255);
            bus.ext_req = 1'b0;

            bus.hold = 1'b1; bus.phase = 3'd2;
            tick(1);
            check("load_over_hold", int'(bus.remaining), 7);
            bus.ext_req = 1'b1;
            tick(1);
            check("ext_while_hold", int'(bus.remaining), 12);
            bus.ext_req = 1'b0; bus.hold = 1'b0;
        end else begin
            bus.phase = 3'd0;
            tick(1);
            check("noext_load", int'(bus.remaining), 10);
            bus.ext_req = 1'b1;
            tick(1);
            check("noext_ignored_a", int'(bus.remaining), 9);
            tick(1);
            check("noext_ignored_b", int'(bus.remaining), 8);
            bus.ext_req = 1'b0;
        end

        bus.phase = 3'd3;
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 8'd20;
        tick(1);
        check("phase3_load", int'(bus.remaining), 3);
        bus.cfg_addr = 3'd1; bus.cfg_data = 8'd8;
        tick(1);
        check("phase3_at_2", int'(bus.remaining), 2);
        bus.cfg_we = 1'b0;
        rst = 1'b0;
        tick(1);
        check("midrun_rst_rem", int'(bus.remaining), 10);
        check("midrun_rst_to", int'(bus.time_out), 0);
        rst = 1'b1;
        tick(1);
        check("post_rst_load_p3", int'(bus.remaining), 3);
        bus.phase = 3'd0;
        tick(1);
        check("table_restored_0", int'(bus.remaining), 10);
        bus.phase = 3'd1;
        tick(1);
        check("table_restored_1", int'(bus.remaining), 3);
        bus.phase = 3'd2;
        tick(1);
        check("table_restored_2", int'(bus.remaining), 10);

        bus.phase = 3'd0;
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 8'd9;
        tick(1);
        check("same_edge_old_dur", int'(bus.remaining), 10);
        bus.cfg_we = 1'b0;
        bus.phase = 3'd1;
        tick(1);
        bus.phase = 3'd0;
        tick(1);
        check("new_dur_next_load", int'(bus.remaining), 9);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
